maxnet_iterator: RTL and testbench

MAXNET_ITERATOR -- requirements
Module: maxnet_iterator

---
 rtl/maxnet_pkg.sv | 14 +
 rtl/maxnet_lane.sv | 17 +
 rtl/maxnet_iterator.sv | 115 +++++++++++
 tb/tb_maxnet_iterator.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/maxnet_pkg.sv
// Shared types and default sizing for the MAXNET winner-take-all iterator.
package maxnet_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH     = 32;
    localparam int DEF_EPS_SHIFT = 3;
    localparam int NUM_LANES     = 4;

endpackage

// File: rtl/maxnet_lane.sv
// One MAXNET lane: lateral inhibition from the other lanes, clamped at zero.
module maxnet_lane #(
    parameter int WIDTH     = 32,
    parameter int EPS_SHIFT = 3
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH+1:0] total,
    output logic [WIDTH-1:0] a_next
);

    logic [WIDTH+1:0] inh;

    // total - a is the sum of the other three lanes, so it never underflows
    assign inh    = (total - {2'b00, a}) >> EPS_SHIFT;
    assign a_next = ({2'b00, a} > inh) ? (a - inh[WIDTH-1:0]) : '0;

endmodule

// File: rtl/maxnet_iterator.sv
// Four-lane MAXNET iterator: shared adder tree, IDLE/ITER/DONE control.
// Define MAXNET_TIMEOUT_EN to end iteration after MAX_ITER updates.
module maxnet_iterator
    import maxnet_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int EPS_SHIFT = DEF_EPS_SHIFT,
    parameter int MAX_ITER  = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] x2,
    input  logic [WIDTH-1:0] x3,
    input  logic [WIDTH-1:0] x4,
    input  logic             winner_found,
    output logic [WIDTH-1:0] A1,
    output logic [WIDTH-1:0] A2,
    output logic [WIDTH-1:0] A3,
    output logic [WIDTH-1:0] A4,
    output logic             busy,
    output logic             result_valid,
    output logic             no_winner,
    output logic [7:0]       iter_count
);

    if (MAX_ITER < 1 || MAX_ITER > 255) begin : g_max_iter_range
        $error("maxnet_iterator: MAX_ITER must be within 1..255");
    end

    state_t                             state_q, state_d;
    logic [NUM_LANES-1:0][WIDTH-1:0]    a_q, a_d, a_next;
    logic [7:0]                         cnt_q, cnt_d, cnt_inc;
    logic                               nw_q, nw_d;
    logic [WIDTH+1:0]                   total;

    assign total = {2'b00, a_q[0]} + {2'b00, a_q[1]} + {2'b00, a_q[2]} + {2'b00, a_q[3]};

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        maxnet_lane #(
            .WIDTH     (WIDTH),
            .EPS_SHIFT (EPS_SHIFT)
        ) u_lane (
            .a      (a_q[i]),
            .total  (total),
            .a_next (a_next[i])
        );
    end

    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        cnt_d   = cnt_q;
        nw_d    = nw_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = {x4, x3, x2, x1};
                    cnt_d   = '0;
                    nw_d    = 1'b0;
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                // winner beats both timeout and stall when they coincide
                if (winner_found) begin
                    nw_d    = 1'b0;
                    state_d = S_DONE;
                end
`ifdef MAXNET_TIMEOUT_EN
                else if (32'(cnt_q) >= MAX_ITER) begin
                    nw_d    = 1'b1;
                    state_d = S_DONE;
                end
`endif
                else begin
                    a_d   = a_next;
                    cnt_d = cnt_inc;
                    if (a_next == a_q) begin
                        nw_d    = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            cnt_q   <= '0;
            nw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            cnt_q   <= cnt_d;
            nw_q    <= nw_d;
        end
    end

    assign A1           = a_q[0];
    assign A2           = a_q[1];
    assign A3           = a_q[2];
    assign A4           = a_q[3];
    assign busy         = (state_q == S_ITER);
    assign result_valid = (state_q == S_DONE);
    assign no_winner    = nw_q;
    assign iter_count   = cnt_q;

endmodule

// File: tb/tb_maxnet_iterator.sv
// Directed bench for maxnet_iterator; winner_found modelled as "exactly one lane nonzero".
module tb_maxnet_iterator;

    localparam int W = 32;
`ifdef MAXNET_TIMEOUT_EN
    localparam int TB_MAX_ITER = 3;
`else
    localparam int TB_MAX_ITER = 255;
`endif

    logic         clk = 1'b0;
    logic         rst, start, winner_found;
    logic [W-1:0] x1, x2, x3, x4;
    logic [W-1:0] A1, A2, A3, A4;
    logic         busy, result_valid, no_winner;
    logic [7:0]   iter_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign winner_found = (int'(A1 != '0) + int'(A2 != '0) + int'(A3 != '0) + int'(A4 != '0)) == 1;

    maxnet_iterator #(
        .WIDTH     (W),
        .EPS_SHIFT (3),
        .MAX_ITER  (TB_MAX_ITER)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .x1           (x1),
        .x2           (x2),
        .x3           (x3),
        .x4           (x4),
        .winner_found (winner_found),
        .A1           (A1),
        .A2           (A2),
        .A3           (A3),
        .A4           (A4),
        .busy         (busy),
        .result_valid (result_valid),
        .no_winner    (no_winner),
        .iter_count   (iter_count)
    );

    typedef struct {
        logic [3:0][W-1:0] x;
        logic [3:0][W-1:0] a;
        int                cnt;
        bit                nw;
    } vec_t;

    function automatic vec_t mk(input int x_1, x_2, x_3, x_4, a_1, a_2, a_3, a_4, cnt, input bit nw);
        vec_t v;
        v.x   = {W'(x_4), W'(x_3), W'(x_2), W'(x_1)};
        v.a   = {W'(a_4), W'(a_3), W'(a_2), W'(a_1)};
        v.cnt = cnt;
        v.nw  = nw;
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [3:0][W-1:0] e);
        chk({tag, "_A1"}, 64'(A1), 64'(e[0]));
        chk({tag, "_A2"}, 64'(A2), 64'(e[1]));
        chk({tag, "_A3"}, 64'(A3), 64'(e[2]));
        chk({tag, "_A4"}, 64'(A4), 64'(e[3]));
    endtask

    task automatic set_x(input logic [3:0][W-1:0] x);
        x1 = x[0]; x2 = x[1]; x3 = x[2]; x4 = x[3];
    endtask

    task automatic pulse_start(input logic [3:0][W-1:0] x);
        set_x(x);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int n = 0;
        while (!result_valid && n < limit) begin
            tick();
            n++;
        end
        chk({tag, "_done_in_budget"}, 64'(result_valid), 64'd1);
    endtask

    task automatic chk_result(input string tag, input vec_t v);
        chk({tag, "_busy"},  64'(busy), 64'd0);
        chk({tag, "_nw"},    64'(no_winner), 64'(v.nw));
        chk({tag, "_cnt"},   64'(iter_count), 64'(v.cnt));
        chk_a(tag, v.a);
    endtask

    vec_t vecs[6];
    vec_t v029;

    initial begin
        rst = 1'b1; start = 1'b0;
        x1 = '0; x2 = '0; x3 = '0; x4 = '0;

        v029 = mk(100, 20, 10, 5, 96, 0, 0, 0, 2, 1'b0);
        vecs[0] = v029;
        vecs[1] = mk(0, 0, 9, 0, 0, 0, 9, 0, 0, 1'b0);
`ifdef MAXNET_TIMEOUT_EN
        vecs[2] = mk(50, 50, 0, 0, 35, 35, 0, 0, 3, 1'b1);
        vecs[4] = mk(1000, 1000, 1000, 1000, 245, 245, 245, 245, 3, 1'b1);
`else
        vecs[2] = mk(50, 50, 0, 0, 7, 7, 0, 0, 19, 1'b1);
        vecs[4] = mk(1000, 1000, 1000, 1000, 2, 2, 2, 2, 16, 1'b1);
`endif
        vecs[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1'b1);
        vecs[5] = mk(0, 0, 0, 8, 0, 0, 0, 8, 0, 1'b0);

        // reset state, with start asserted to show reset wins
        start = 1'b1; x1 = 32'd7;
        tick(); tick();
        start = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rv",   64'(result_valid), 64'd0);
        chk("rst_nw",   64'(no_winner), 64'd0);
        chk("rst_cnt",  64'(iter_count), 64'd0);
        chk_a("rst", '0);
        rst = 1'b0;
        tick();
        chk("idle_busy", 64'(busy), 64'd0);

        // cycle-by-cycle trace of the (100,20,10,5) case
        pulse_start(v029.x);
        chk("t_load_busy", 64'(busy), 64'd1);
        chk("t_load_rv",   64'(result_valid), 64'd0);
        chk_a("t_load", v029.x);
        tick();
        chk_a("t_it1", {W'(0), W'(0), W'(6), W'(96)});
        chk("t_it1_cnt", 64'(iter_count), 64'd1);
        tick();
        chk_a("t_it2", {W'(0), W'(0), W'(0), W'(96)});
        chk("t_it2_cnt", 64'(iter_count), 64'd2);
        tick();
        chk("t_done_rv", 64'(result_valid), 64'd1);
        chk_result("t_done", v029);
        tick(); tick(); tick();
        chk("t_hold_rv", 64'(result_valid), 64'd1);
        chk_result("t_hold", v029);

        // table of full runs, each started from DONE of the previous
        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            pulse_start(vecs[i].x);
            wait_done(tag, 400);
            chk_result(tag, vecs[i]);
        end

        // full-scale inputs: one update must not overflow the adder tree
        pulse_start({4{W'(32'hFFFF_FFFF)}});
        tick();
        chk_a("big_it1", {4{W'(32'hA000_0000)}});

        // reset mid-iteration, with a start pulse in ITER that must be ignored
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_cnt",  64'(iter_count), 64'd0);
        chk_a("midrst", '0);
        pulse_start(v029.x);
        tick();
        chk_a("midrst_it1", {W'(0), W'(0), W'(6), W'(96)});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_busy", 64'(busy), 64'd0);
        chk("rst2_rv",   64'(result_valid), 64'd0);
        chk_a("rst2", '0);

        pulse_start(v029.x);
        set_x({W'(4), W'(3), W'(2), W'(1)});
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        chk("ign_busy", 64'(busy), 64'd1);
        wait_done("rerun", 50);
        chk_result("rerun", v029);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
